// File: rtl/fsm_3_if.sv
// Bus between fsm_3 and its client: conversion request, operand, BCD result and status.
// The master drives start/a; the slave (fsm_3) returns the digits, busy/done and a state tap.
interface fsm_3_if;
    // start is a request sampled only while busy is low. A request seen on a clock
    // edge with busy low is accepted on that edge. busy then stays high until
    // done pulses. Requests made while busy is high are dropped, not queued.
    logic       start;
    logic [7:0] a;
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] z;
    logic       busy;
    logic       done;
    logic       dbg_conv;

    modport master (
        output start, a,
        input  x, y, z, busy, done, dbg_conv
    );

    modport slave (
        input  start, a,
        output x, y, z, busy, done, dbg_conv
    );
endinterface

// File: rtl/fsm_3.sv
// Sequential 8-bit binary to 3-digit BCD converter (double-dabble, one bit per clock).
// Optional macro FSM_3_AUTOSTART_EN: convert automatically whenever the operand changes.
module fsm_3 (
    input  logic   clk,
    input  logic   rst,
    fsm_3_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [19:0] sr_q, sr_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  x_q, x_d;
    logic [3:0]  y_q, y_d;
    logic [3:0]  z_q, z_d;
    logic        done_q, done_d;
    logic [19:0] sr_adj;
    logic [19:0] sr_shift;
    logic        launch;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // Correct every BCD nibble before the shift so a doubled digit carries properly.
    always_comb begin
        sr_adj   = {add3(sr_q[19:16]), add3(sr_q[15:12]), add3(sr_q[11:8]), sr_q[7:0]};
        sr_shift = sr_adj << 1;
    end

`ifdef FSM_3_AUTOSTART_EN
    logic [7:0] last_a_q, last_a_d;
    logic       first_q, first_d;

    assign launch = first_q || (bus.a != last_a_q);

    always_comb begin
        last_a_d = last_a_q;
        first_d  = first_q;
        if ((state_q == IDLE) && launch) begin
            last_a_d = bus.a;
            first_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_a_q <= 8'd0;
            first_q  <= 1'b1;
        end else begin
            last_a_q <= last_a_d;
            first_q  <= first_d;
        end
    end
`else
    assign launch = bus.start;
`endif

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (launch) begin
                    sr_d    = {12'd0, bus.a};
                    cnt_d   = 3'd0;
                    state_d = CONV;
                end
            end
            CONV: begin
                sr_d  = sr_shift;
                cnt_d = cnt_q + 3'd1;
                // Last bit shifted in: publish all three digits at once.
                if (cnt_q == 3'd7) begin
                    x_d     = sr_shift[19:16];
                    y_d     = sr_shift[15:12];
                    z_d     = sr_shift[11:8];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= 20'd0;
            cnt_q   <= 3'd0;
            x_q     <= 4'd0;
            y_q     <= 4'd0;
            z_q     <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            done_q  <= done_d;
        end
    end

    assign bus.x        = x_q;
    assign bus.y        = y_q;
    assign bus.z        = z_q;
    assign bus.done     = done_q;
    assign bus.busy     = (state_q == CONV);
    assign bus.dbg_conv = (state_q == CONV);

endmodule

// File: tb/tb_fsm_3.sv
// Directed bench for fsm_3 in its default (start-triggered) build.
// Hand-computed BCD vectors, latency/busy/done checks, reset abort and a full 0-255 sweep.
module tb_fsm_3;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    fsm_3_if bus ();

    fsm_3 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // One start pulse, then watch latency, busy length, result and single-cycle done.
    task automatic run_conv(input logic [7:0] val, input logic [7:0] val_after,
                            input logic [11:0] exp_bcd, input string tag);
        int busy_cnt;
        int done_at;
        @(negedge clk);
        bus.a     = val;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = val_after;
        busy_cnt  = 0;
        done_at   = 0;
        for (int k = 1; k <= 20 && done_at == 0; k++) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (bus.done) done_at = k;
        end
        check({tag, "_latency"}, done_at, 9);
        check({tag, "_busy_len"}, busy_cnt, 8);
        check({tag, "_bcd"}, {bus.x, bus.y, bus.z}, exp_bcd);
        check({tag, "_sum"}, 100 * bus.x + 10 * bus.y + bus.z, val);
        @(negedge clk);
        check({tag, "_done_pulse"}, bus.done, 1'b0);
    endtask

    initial begin
        int done_cnt;
        int first_done;
        int second_done;
        logic [7:0]  v;
        logic [11:0] exp_bcd;

        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = 8'd0;
        repeat (2) @(negedge clk);
        check("reset_bcd", {bus.x, bus.y, bus.z}, 12'h000);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_done", bus.done, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        run_conv(8'd0,   8'd0,  12'h000, "a0");
        run_conv(8'd4,   8'd4,  12'h004, "a4");
        run_conv(8'd22,  8'd22, 12'h022, "a22");
        run_conv(8'd234, 8'd17, 12'h234, "a234");
        run_conv(8'd255, 8'd0,  12'h255, "a255");
        run_conv(8'd100, 8'd3,  12'h100, "a100");
        run_conv(8'd55,  8'd55, 12'h055, "a55");

        // Outputs hold while idle even when a moves.
        bus.a = 8'd77;
        repeat (5) @(negedge clk);
        check("hold_bcd", {bus.x, bus.y, bus.z}, 12'h055);
        check("hold_busy", bus.busy, 1'b0);

        // Start held high: a second conversion may only begin in the done cycle.
        bus.a       = 8'd55;
        bus.start   = 1'b1;
        done_cnt    = 0;
        first_done  = 0;
        second_done = 0;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (bus.done) begin
                done_cnt++;
                if (first_done == 0) first_done = k;
                else second_done = k;
            end
        end
        bus.start = 1'b0;
        check("held_done_count", done_cnt, 2);
        check("held_first_done", first_done, 9);
        check("held_second_done", second_done, 18);
        repeat (3) @(negedge clk);
        check("held_idle_busy", bus.busy, 1'b0);

        // Reset during iteration 4 of a=199 aborts without a done pulse.
        @(negedge clk);
        bus.a     = 8'd199;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_busy_before", bus.busy, 1'b1);
        rst = 1'b1;
        #1;
        check("abort_bcd", {bus.x, bus.y, bus.z}, 12'h000);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_done", bus.done, 1'b0);
        @(negedge clk);
        rst      = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        check("abort_bcd_after", {bus.x, bus.y, bus.z}, 12'h000);

        run_conv(8'd199, 8'd199, 12'h199, "a199");

        // Full operand sweep against an arithmetic digit model.
        for (int i = 0; i < 256; i++) begin
            v       = 8'(i);
            exp_bcd = {4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)};
            run_conv(v, 8'($urandom_range(0, 255)), exp_bcd, "sweep");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
